// File: rtl/audio_play_streamer_if.sv
// Stream-in / codec-out signal bundle for audio_play_streamer.
// The slave side is the streamer; the master side is the source/codec environment.
interface audio_play_streamer_if #(
    parameter int SAMPLE_W = 16
);
    logic [2*SAMPLE_W-1:0] snk_data;
    logic                  snk_valid;
    logic                  snk_ready;
    logic [SAMPLE_W-1:0]   dac_left;
    logic [SAMPLE_W-1:0]   dac_right;
    logic                  dac_strobe;

    modport slave (
        input  snk_data, snk_valid,
        output snk_ready, dac_left, dac_right, dac_strobe
    );

    modport master (
        output snk_data, snk_valid,
        input  snk_ready, dac_left, dac_right, dac_strobe
    );
endinterface

// File: rtl/audio_play_streamer.sv
// Play-gated stereo frame FIFO: prefills, then hands one frame to the codec per
// sample tick, muting and counting underruns; a stop flushes everything queued.
module audio_play_streamer #(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 16,
    parameter int PREFILL  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 play,
    input  logic                 sample_tick,
    audio_play_streamer_if.slave bus,
    output logic                 playing,
    output logic [15:0]          underrun_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PREFILL_C = CNT_W'(PREFILL);

    typedef enum logic [1:0] {IDLE, PREFILL_ST, PLAY} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [SAMPLE_W-1:0]   dac_left_q, dac_left_d, dac_right_q, dac_right_d;
    logic                  dac_strobe_q, dac_strobe_d;
    logic [15:0]           underrun_q, underrun_d;
    logic [2*SAMPLE_W-1:0] mem_q [DEPTH];
    logic [2*SAMPLE_W-1:0] head;
    logic                  snk_ready, push, pop;

    assign snk_ready = (state_q != IDLE) && (count_q < DEPTH_C);
    assign push      = bus.snk_valid && snk_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dac_left_d   = dac_left_q;
        dac_right_d  = dac_right_q;
        dac_strobe_d = 1'b0;
        underrun_d   = underrun_q;
        pop          = 1'b0;

        case (state_q)
            IDLE: begin
                if (play) state_d = PREFILL_ST;
            end
            PREFILL_ST: begin
                if (play && sample_tick) begin
                    dac_strobe_d = 1'b1;
                    dac_left_d   = '0;
                    dac_right_d  = '0;
                end
            end
            PLAY: begin
                if (play && sample_tick) begin
                    dac_strobe_d = 1'b1;
                    if (count_q != '0) begin
                        pop         = 1'b1;
                        dac_left_d  = head[2*SAMPLE_W-1:SAMPLE_W];
                        dac_right_d = head[SAMPLE_W-1:0];
                    end else begin
                        dac_left_d  = '0;
                        dac_right_d = '0;
                        if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Same-cycle push is already folded into count_d before the threshold test.
        if (state_q == PREFILL_ST && play && count_d >= PREFILL_C) state_d = PLAY;

        // Stop wins over everything, including a push accepted this very cycle.
        if (state_q != IDLE && !play) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            dac_left_d   = '0;
            dac_right_d  = '0;
            dac_strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dac_left_q   <= '0;
            dac_right_q  <= '0;
            dac_strobe_q <= 1'b0;
            underrun_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dac_left_q   <= dac_left_d;
            dac_right_q  <= dac_right_d;
            dac_strobe_q <= dac_strobe_d;
            underrun_q   <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.snk_data;
    end

    assign bus.snk_ready  = snk_ready;
    assign bus.dac_left   = dac_left_q;
    assign bus.dac_right  = dac_right_q;
    assign bus.dac_strobe = dac_strobe_q;
    assign playing        = (state_q == PLAY);
    assign underrun_cnt   = underrun_q;
endmodule
